// File: rtl/baseline_detector_pkg.sv
// baseline_detector_pkg
//   Shared definitions for the baseline detector slice: FSM state encodings
//   and the default sample-counter width.
//   No ports (package).
package baseline_detector_pkg;

   localparam int DEF_CNT_WIDTH = 8;

   // Encodings 5..7 are illegal; the detector steers them back to S_IDLE.
   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_ARMED      = 3'd1,
      S_PENDING    = 3'd2,
      S_ALARM      = 3'd3,
      S_REFRACTORY = 3'd4
   } state_t;

endpackage

// File: rtl/baseline_detector_sample_counter.sv
// sample_counter
//   Loadable down-counter used for the hold and refractory timers.
//   Load takes priority over decrement; decrement stops at zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val into the counter
//   load_val   : value to load
//   dec        : decrement by one (ignored when already zero)
//   count      : current count
//   zero       : count == 0
module sample_counter
   import baseline_detector_pkg::*;
#(
   parameter int cnt_width = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [cnt_width-1:0] load_val,
   input  logic                 dec,
   output logic [cnt_width-1:0] count,
   output logic                 zero
);

   logic [cnt_width-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/baseline_detector.sv
// baseline_detector
//   Latches the most recent baseline, scales it by thresh_mult into a
//   threshold and compares each feature sample against it (strict >).
//   A debounce / hold / refractory FSM turns raw exceedances into a clean
//   alarm level plus a one-cycle onset pulse.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   en              : active-low enable; high freezes all state
//   din, din_valid  : signed feature sample and its one-cycle qualifier
//   baseline_in,
//   baseline_valid  : signed baseline and its qualifier
//   thresh_mult     : unsigned threshold multiplier
//   alarm           : registered alarm level
//   onset           : registered one-cycle pulse on alarm entry
//   baseline_ready  : a baseline has been latched since reset
//   state_dbg       : current FSM state encoding
//
// Handshake: din_valid and baseline_valid are pure qualifiers. A transfer
// happens on every clock where the valid is high and en is low; there is no
// ready/backpressure, so one sample per cycle is always accepted.
module baseline_detector
   import baseline_detector_pkg::*;
#(
   parameter int feature_width    = 25,
   parameter int baseline_width   = 34,
   parameter int mult_width       = 4,
   parameter int cnt_width        = 8,
   parameter int onset_count      = 3,
   parameter int hold_count       = 10,
   parameter int refractory_count = 20
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             en,
   input  logic signed [feature_width-1:0]  din,
   input  logic                             din_valid,
   input  logic signed [baseline_width-1:0] baseline_in,
   input  logic                             baseline_valid,
   input  logic [mult_width-1:0]            thresh_mult,
   output logic                             alarm,
   output logic                             onset,
   output logic                             baseline_ready,
   output logic [2:0]                       state_dbg
);

   localparam int thr_width = baseline_width + mult_width + 1;
   localparam logic [cnt_width-1:0] onset_cnt = cnt_width'(onset_count);
   localparam logic [cnt_width-1:0] hold_cnt  = cnt_width'(hold_count);
   localparam logic [cnt_width-1:0] refr_cnt  = cnt_width'(refractory_count);

   state_t                      state_q, state_d;
   logic [cnt_width-1:0]        run_q, run_d, run_inc;
   logic signed [baseline_width-1:0] base_q;
   logic                        ready_q, alarm_q, onset_q;

   logic signed [thr_width-1:0] base_ext, mult_ext, thr, din_ext;
   logic                        sample, latch, exceed, illegal;

   logic                        hold_load, hold_dec, hold_zero;
   logic                        refr_load, refr_dec, refr_zero;
   logic [cnt_width-1:0]        hold_val, refr_val;

   assign sample = din_valid && !en;
   assign latch  = baseline_valid && !en;

   // Multiplier is zero-extended so it is always non-negative; the baseline
   // keeps its sign, so a negative baseline yields a negative threshold.
   assign base_ext = thr_width'(base_q);
   assign mult_ext = $signed({{(thr_width-mult_width){1'b0}}, thresh_mult});
   assign thr      = base_ext * mult_ext;
   assign din_ext  = thr_width'(din);
   // base_q is the registered value, so a baseline arriving with a sample
   // only affects the following samples.
   assign exceed   = din_ext > thr;

   assign illegal  = (state_q > S_REFRACTORY);
   assign run_inc  = (run_q >= onset_cnt) ? onset_cnt : run_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      run_d     = run_q;
      hold_load = 1'b0;
      hold_dec  = 1'b0;
      refr_load = 1'b0;
      refr_dec  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (latch) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (sample && exceed) begin
               run_d = cnt_width'(1);
               if (onset_cnt == cnt_width'(1)) begin
                  state_d   = S_ALARM;
                  hold_load = 1'b1;
               end else begin
                  state_d = S_PENDING;
               end
            end
         end
         S_PENDING: begin
            if (sample) begin
               if (exceed) begin
                  run_d = run_inc;
                  if (run_inc == onset_cnt) begin
                     state_d   = S_ALARM;
                     hold_load = 1'b1;
                  end
               end else begin
                  run_d   = '0;
                  state_d = S_ARMED;
               end
            end
         end
         S_ALARM: begin
            if (sample) begin
               if (exceed) begin
                  hold_load = 1'b1;
               end else begin
                  hold_dec = 1'b1;
                  // This sample takes hold to zero (or it already was).
                  if (hold_zero || hold_val == cnt_width'(1)) begin
                     state_d   = S_REFRACTORY;
                     refr_load = 1'b1;
                  end
               end
            end
         end
         S_REFRACTORY: begin
            if (sample) begin
               refr_dec = 1'b1;
               if (refr_zero || refr_val == cnt_width'(1)) state_d = S_ARMED;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         run_q   <= '0;
         base_q  <= '0;
         ready_q <= 1'b0;
         alarm_q <= 1'b0;
         onset_q <= 1'b0;
      end else begin
         // Illegal encodings recover even while frozen.
         if (!en || illegal) state_q <= state_d;
         if (!en) begin
            run_q   <= run_d;
            alarm_q <= (state_q == S_ALARM);
            onset_q <= (state_q == S_ALARM) && !alarm_q;
            if (latch) begin
               base_q  <= baseline_in;
               ready_q <= 1'b1;
            end
         end else begin
            onset_q <= 1'b0;
         end
      end
   end

   sample_counter #(.cnt_width(cnt_width)) u_hold (
      .clk      (clk),
      .rst      (rst),
      .load     (hold_load),
      .load_val (hold_cnt),
      .dec      (hold_dec),
      .count    (hold_val),
      .zero     (hold_zero)
   );

   sample_counter #(.cnt_width(cnt_width)) u_refr (
      .clk      (clk),
      .rst      (rst),
      .load     (refr_load),
      .load_val (refr_cnt),
      .dec      (refr_dec),
      .count    (refr_val),
      .zero     (refr_zero)
   );

   assign alarm          = alarm_q;
   assign onset          = onset_q;
   assign baseline_ready = ready_q;
   assign state_dbg      = state_q;

endmodule
